// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
package ro_meas_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        StIdle,
        StGate,
        StSend
    } meas_state_e;

    // Upper seven bits of the optional header byte; the LSB carries overflow
    localparam logic [6:0] HDR_BASE = 7'b1010010;

    // Number of count bytes transmitted for a given edge-counter width
    function automatic int unsigned num_bytes(input int unsigned cnt_w);
        return cnt_w / 8;
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Produces a one-cycle pulse in the clk domain for each rising edge of async_in.
module ro_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Synchronizer chain and delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
        end
    end

    assign edge_pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Gated frequency counter and byte serializer for the ring-oscillator sensor.
// Counts synchronized ro_in edges over GATE_CYCLES clocks, then sends the
// count MSB byte first over a valid/ready handshake.
// Optional feature: define RO_MEAS_HEADER_EN to prefix a header byte
// {HDR_BASE, overflow} ahead of the count bytes.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 4096,
    parameter int unsigned GATE_W      = 16,
    parameter int unsigned CNT_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ro_in,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned NUM_BYTES = num_bytes(CNT_W);
`ifdef RO_MEAS_HEADER_EN
    localparam int unsigned SEND_BYTES = NUM_BYTES + 1;
`else
    localparam int unsigned SEND_BYTES = NUM_BYTES;
`endif
    localparam int unsigned SHIFT_W = 8 * SEND_BYTES;
    localparam int unsigned IDX_W   = $clog2(SEND_BYTES + 1);

    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SEND_BYTES - 1);

    meas_state_e         state_q, state_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                overflow_q, overflow_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;

    logic                edge_pulse;
    logic [CNT_W-1:0]    cnt_next;
    logic                ovf_next;
    logic                accept;

    ro_edge_sync u_edge_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (ro_in),
        .edge_pulse (edge_pulse)
    );

    assign accept = tx_valid_q & tx_ready;

    // Saturating edge count including this cycle's pulse
    always_comb begin
        cnt_next = edge_cnt_q;
        ovf_next = overflow_q;
        if (edge_pulse) begin
            if (&edge_cnt_q) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = edge_cnt_q + 1'b1;
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        overflow_d = overflow_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StGate;
                    gate_cnt_d = GATE_LOAD;
                    edge_cnt_d = '0;
                    overflow_d = 1'b0;
                end
            end
            StGate: begin
                edge_cnt_d = cnt_next;
                overflow_d = ovf_next;
                if (gate_cnt_q == '0) begin
                    // Last gate cycle: latch the final count, including this cycle's edge
                    state_d    = StSend;
                    byte_idx_d = '0;
`ifdef RO_MEAS_HEADER_EN
                    shift_d    = {HDR_BASE, ovf_next, cnt_next};
`else
                    shift_d    = cnt_next;
`endif
                    tx_data_d  = shift_d[SHIFT_W-1 -: 8];
                    tx_valid_d = 1'b1;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            StSend: begin
                if (accept) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d    = StIdle;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        shift_d    = shift_q << 8;
                        tx_data_d  = shift_d[SHIFT_W-1 -: 8];
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            overflow_q <= 1'b0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != StIdle);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: a GATE_CYCLES=16/CNT_W=24 instance and a
// GATE_CYCLES=600/CNT_W=8 instance for the saturation case.
module tb_ro_meas_ctrl;

`ifdef RO_MEAS_HEADER_EN
    localparam int NB_EXP  = 4;
    localparam int NB2_EXP = 2;
`else
    localparam int NB_EXP  = 3;
    localparam int NB2_EXP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ro_main = 1'b0;
    logic       ro4_en = 1'b0;
    logic       ro_fast = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid, busy, overflow;

    logic       start2 = 1'b0;
    logic [7:0] tx_data2;
    logic       tx_valid2, busy2, overflow2;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] got [8];
    int         nb, lat;
    logic [7:0] b0;

    ro_meas_ctrl #(
        .GATE_CYCLES (16),
        .GATE_W      (16),
        .CNT_W       (24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ro_in    (ro_main),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .overflow (overflow)
    );

    ro_meas_ctrl #(
        .GATE_CYCLES (600),
        .GATE_W      (16),
        .CNT_W       (8)
    ) dut2 (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .ro_in    (ro_fast),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .tx_ready (1'b1),
        .busy     (busy2),
        .overflow (overflow2)
    );

    always #5 clk = ~clk;

    // Oscillator stimulus: period-4 train for the main DUT, period-2 for dut2
    int ph = 0;
    always @(negedge clk) begin
        ph = ph + 1;
        ro_main = ro4_en ? ph[1] : 1'b0;
        ro_fast = ~ro_fast;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input logic [23:0] c, input logic ovf);
        int j;
        j = k;
`ifdef RO_MEAS_HEADER_EN
        if (j == 0) return {7'b1010010, ovf};
        j = j - 1;
`endif
        return c[8*(2-j) +: 8];
    endfunction

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Counts cycles from the start cycle until tx_valid; optional start poke mid-gate
    task automatic wait_valid(input int poke, output int lat_o);
        lat_o = 1;
        while (!tx_valid && lat_o < 2000) begin
            start = (lat_o == poke);
            @(posedge clk); #1;
            lat_o++;
        end
        start = 1'b0;
    endtask

    // Collects bytes while tx_valid; optional stall on one byte and start poke
    task automatic collect(input int poke, input int stall, output int nb_o);
        logic stable;
        nb_o = 0;
        while (tx_valid && nb_o < 8) begin
            got[nb_o] = tx_data;
            if (nb_o == stall) begin
                tx_ready = 1'b0;
                stable = 1'b1;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (tx_valid !== 1'b1 || tx_data !== got[nb_o]) stable = 1'b0;
                end
                check("stall_hold", 32'(stable), 32'd1);
                tx_ready = 1'b1;
            end
            nb_o++;
            start = (nb_o == poke);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [23:0] c);
        check({tag, "_nbytes"}, 32'(n), 32'(NB_EXP));
        for (int k = 0; k < NB_EXP; k++) begin
            if (k < n) check($sformatf("%s_b%0d", tag, k), 32'(got[k]), 32'(exp_byte(k, c, 1'b0)));
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_tx_valid2", 32'(tx_valid2), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        reset = 1'b0;

        // ro_in held low: zero count, latency 17
        do_start();
        check("zero_busy_rise", 32'(busy), 32'd1);
        wait_valid(0, lat);
        check("zero_latency", 32'(lat), 32'd17);
        collect(0, -1, nb);
        check_bytes("zero", nb, 24'd0);
        check("zero_busy_fall", 32'(busy), 32'd0);
        check("zero_overflow", 32'(overflow), 32'd0);

        // Stall on byte 1 for 10 cycles
        do_start();
        wait_valid(0, lat);
        collect(0, 1, nb);
        check_bytes("stall", nb, 24'd0);
        check("stall_busy_fall", 32'(busy), 32'd0);

        // start pokes during GATE and SEND are ignored
        do_start();
        wait_valid(8, lat);
        check("poke_latency", 32'(lat), 32'd17);
        collect(2, -1, nb);
        check_bytes("poke", nb, 24'd0);
        check("poke_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("poke_still_idle", 32'(busy), 32'd0);

        // Period-4 oscillator: 4 edges in a 16-cycle window
        ro4_en = 1'b1;
        repeat (8) @(posedge clk);
        do_start();
        wait_valid(0, lat);
        check("p4_latency", 32'(lat), 32'd17);
        collect(0, -1, nb);
        check_bytes("p4", nb, 24'd4);

        // Reset in SEND after byte 0 accepted
        do_start();
        wait_valid(0, lat);
        b0 = tx_data;
        check("rsend_b0", 32'(b0), 32'(exp_byte(0, 24'd4, 1'b0)));
        @(posedge clk); #1;
        check("rsend_valid_pre", 32'(tx_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("rsend_tx_valid", 32'(tx_valid), 32'd0);
        check("rsend_busy", 32'(busy), 32'd0);
        check("rsend_overflow", 32'(overflow), 32'd0);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        do_start();
        wait_valid(0, lat);
        check("rnew_latency", 32'(lat), 32'd17);
        collect(0, -1, nb);
        check_bytes("rnew", nb, 24'd4);

        // Saturation: CNT_W=8, period-2 input over 600 cycles
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        lat = 1;
        while (!tx_valid2 && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("sat_latency", 32'(lat), 32'd601);
        check("sat_overflow", 32'(overflow2), 32'd1);
        nb = 0;
        while (tx_valid2 && nb < 8) begin
            got[nb] = tx_data2;
            nb++;
            @(posedge clk); #1;
        end
        check("sat_nbytes", 32'(nb), 32'(NB2_EXP));
`ifdef RO_MEAS_HEADER_EN
        check("sat_header", 32'(got[0]), 32'hA5);
        check("sat_byte", 32'(got[1]), 32'hFF);
`else
        check("sat_byte", 32'(got[0]), 32'hFF);
`endif
        check("sat_busy_fall", 32'(busy2), 32'd0);
        check("sat_overflow_sticky", 32'(overflow2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_meas_ctrl.md
# ro_meas_ctrl

Gated frequency counter and result serializer for the ring-oscillator temperature sensor. It counts rising edges of the selected, prescaled oscillator output over a fixed window of system clocks. It then hands the count, byte by byte, to the UART transmitter over a valid/ready handshake. A measurement starts on a one-cycle pulse from the UART receive path, so any received byte triggers a new reading.

## Interface

Parameters:
- GATE_CYCLES, 4096, gate window length in clk cycles; legal range 1 to 2^GATE_W-1
- GATE_W, 16, width of the gate down-counter
- CNT_W, 24, edge-counter width; must be a multiple of 8 (NUM_BYTES = CNT_W/8)

Ports:
- clk  in  1  system clock (internal or external, already muxed upstream)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle measurement request (UART RX byte-valid)
- ro_in  in  1  prescaled ring-oscillator output, asynchronous to clk
- tx_data  out  8  byte offered to the UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts the byte this cycle
- busy  out  1  high in any state other than IDLE
- overflow  out  1  sticky saturation flag of the last measurement

## Operation

- The FSM has three states: IDLE, GATE and SEND.
- IDLE: start=1 moves to GATE. On the same edge:
  - the gate counter loads GATE_CYCLES-1;
  - the edge counter clears;
  - overflow clears.
- GATE lasts exactly GATE_CYCLES cycles.
  - Each cycle in which the synchronized edge pulse is high increments the edge counter.
  - The edge counter saturates at all-ones. Overflow sets on an attempted increment past all-ones.
- When the gate counter reaches 0:
  - the count latches into the shift register;
  - the byte index resets to 0;
  - the FSM goes to SEND.
- SEND: tx_valid=1 and tx_data = the current byte, MSB byte first.
  - On tx_valid && tx_ready, advance to the next byte.
  - After the last byte is accepted, return to IDLE.
- start is ignored while busy=1. No queuing.
- The synchronizer and edge detect run in every state. Edges are counted only in GATE.
- Reset: asynchronous, to IDLE. All outputs are 0 and all counters clear.

## Timing

- ro_in path: 2-flop synchronizer plus a 1-flop edge detect. A rising edge of ro_in produces a one-cycle pulse 3 cycles later, subject to ±1 cycle of synchronizer uncertainty.
- ro_in must be slower than clk/2. Faster inputs alias and are not detected as an error.
- Latency from start to first tx_valid: GATE_CYCLES+1 cycles. tx_valid rises the cycle after the last gate cycle.
- tx_data and tx_valid are registered. They hold stable while tx_valid && !tx_ready.
- Back-to-back bytes are allowed: the next byte is presented the cycle after acceptance.
- busy rises the cycle after start and falls the cycle after the last byte is accepted.
- Boundaries:
  - GATE_CYCLES=1 gives a one-cycle window.
  - A saturated count transmits as all-0xFF.
  - tx_ready held low stalls SEND indefinitely.
  - A reset during SEND drops tx_valid immediately and discards the remaining bytes.

## Configuration

- RO_MEAS_HEADER_EN defined:
  - SEND first transmits a header byte {7'b1010010, overflow} (0xA4 or 0xA5), then NUM_BYTES count bytes.
  - The byte index spans 0..NUM_BYTES.
  - Latency to the first count byte is unchanged apart from the header transfer.
- Undefined: only NUM_BYTES count bytes are sent. overflow is visible only on its port.

## Structure

- Package ro_meas_pkg holds:
  - the FSM state enum (IDLE, GATE, SEND);
  - the header constants HDR_BASE = 7'b1010010;
  - the function computing NUM_BYTES from CNT_W.
- Sub-module ro_edge_sync: 2-flop synchronizer plus rising-edge detector.
  - Ports: clk, reset, async_in, edge_pulse.
  - Reused for other asynchronous inputs in the sensor.

## Test plan

Bench settings: GATE_CYCLES=16, CNT_W=24, header off unless stated.

- ro_in held 0, pulse start, tx_ready=1:
  - bytes 0x00, 0x00, 0x00 on consecutive cycles;
  - first tx_valid 17 cycles after start;
  - busy falls after the third byte.
- ro_in with a period of 4 clk, phase pinned so the pulses fall at gate cycles 1, 5, 9, 13:
  - count 4, bytes 0x00, 0x00, 0x04.
- CNT_W=8, ro_in with a period of 2 clk, GATE_CYCLES=600:
  - byte 0xFF;
  - overflow=1.
  - With RO_MEAS_HEADER_EN, the header is 0xA5 before 0xFF.
- tx_ready low for 10 cycles during byte 1:
  - tx_data stays 0x00 and tx_valid stays high;
  - after release, the sequence completes unchanged.
- start pulsed again during GATE and during SEND:
  - no restart;
  - the gate length stays 16 and exactly 3 bytes are sent.
- reset asserted during SEND after byte 0 is accepted:
  - tx_valid=0, busy=0 and overflow=0 asynchronously;
  - a new start gives a fresh, correct 3-byte result.
